// File: rtl/fp_alu_pkg.sv
// Shared definitions for the FP add/sub dispatcher: FSM encoding, status flag
// positions and operation codes.
package fp_alu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } disp_state_e;

    localparam int FLAG_W         = 5;
    localparam int FLAG_ZERO      = 0;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_NAN       = 3;
    localparam int FLAG_TIMEOUT   = 4;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/fp_op_dispatcher_if.sv
// Request, adder and result signals of the FP dispatcher; the dispatcher takes
// the slave side, the environment (requester + adder + consumer) the master side.
interface fp_op_dispatcher_if #(
    parameter int N = 31
);
    import fp_alu_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [N:0]        in_a;
    logic [N:0]        in_b;
    logic              in_op;

    logic [N:0]        add_a;
    logic [N:0]        add_b;
    logic              add_load;
    logic              add_enable;
    logic [N:0]        add_result;
    logic              add_done;
    logic              add_zero;
    logic              add_overflow;
    logic              add_underflow;
    logic              add_nan;

    logic              out_valid;
    logic              out_ready;
    logic [N:0]        out_result;
    logic [FLAG_W-1:0] out_flags;

    modport master (
        output in_valid, in_a, in_b, in_op,
        output add_result, add_done, add_zero, add_overflow, add_underflow, add_nan,
        output out_ready,
        input  in_ready, add_a, add_b, add_load, add_enable,
        input  out_valid, out_result, out_flags
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op,
        input  add_result, add_done, add_zero, add_overflow, add_underflow, add_nan,
        input  out_ready,
        output in_ready, add_a, add_b, add_load, add_enable,
        output out_valid, out_result, out_flags
    );

endinterface

// File: rtl/fp_req_fifo.sv
// Request buffer: DEPTH-entry (power of two) synchronous FIFO with the head
// entry always visible on pop_data.
module fp_req_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok, pop_ok;

    assign full     = (count_q == DEPTH_C);
    assign empty    = (count_q == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/fp_op_dispatcher.sv
// Buffers FP add/sub requests and feeds them one at a time to an external adder,
// returning each result (or a timeout) in request order.
//   IDLE | waiting for a buffered request    LOAD | pulse add_load, clear timer/armed
//   WAIT | waiting for a fresh add_done      HOLD | result presented until out_ready
module fp_op_dispatcher
    import fp_alu_pkg::*;
#(
    parameter int Mantissa_Size = 23,
    parameter int Exponent_Size = 8,
    parameter int FIFO_DEPTH    = 4,
    parameter int TIMEOUT       = 32
) (
    input logic               clk,
    input logic               rst_n,
    fp_op_dispatcher_if.slave bus
);
    localparam int N     = Mantissa_Size + Exponent_Size;
    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    disp_state_e       state_q, state_d;
    logic [N:0]        add_a_q, add_a_d;
    logic [N:0]        add_b_q, add_b_d;
    logic [N:0]        res_q, res_d;
    logic [FLAG_W-1:0] flags_q, flags_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              armed_q, armed_d;

    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [N:0]        b_stored;
    logic [2*N+1:0]    fifo_head;

    // Subtraction is folded into the request by flipping B's sign on entry.
    assign b_stored  = (bus.in_op == OP_SUB) ? {~bus.in_b[N], bus.in_b[N-1:0]} : bus.in_b;
    assign fifo_push = bus.in_valid && bus.in_ready;
    assign fifo_pop  = (state_q == ST_IDLE) && !fifo_empty;

    fp_req_fifo #(
        .WIDTH (2*N+2),
        .DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data ({bus.in_a, b_stored}),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign bus.in_ready   = rst_n && !fifo_full;
    assign bus.add_enable = rst_n;
    assign bus.add_load   = (state_q == ST_LOAD);
    assign bus.add_a      = add_a_q;
    assign bus.add_b      = add_b_q;
    assign bus.out_valid  = (state_q == ST_HOLD);
    assign bus.out_result = res_q;
    assign bus.out_flags  = flags_q;

    always_comb begin
        state_d = state_q;
        add_a_d = add_a_q;
        add_b_d = add_b_q;
        res_d   = res_q;
        flags_d = flags_q;
        cnt_d   = cnt_q;
        armed_d = armed_q;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    add_a_d = fifo_head[2*N+1:N+1];
                    add_b_d = fifo_head[N:0];
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                cnt_d   = '0;
                armed_d = 1'b0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A done left high by the previous operation is ignored until it has been seen low.
                if (!bus.add_done) begin
                    armed_d = 1'b1;
                end
                if (armed_q && bus.add_done) begin
                    res_d                   = bus.add_result;
                    flags_d                 = '0;
                    flags_d[FLAG_NAN]       = bus.add_nan;
                    flags_d[FLAG_OVERFLOW]  = bus.add_overflow;
                    flags_d[FLAG_UNDERFLOW] = bus.add_underflow;
                    flags_d[FLAG_ZERO]      = bus.add_zero;
                    state_d                 = ST_HOLD;
                end else if (cnt_q == CNT_LAST) begin
                    res_d                 = '0;
                    flags_d               = '0;
                    flags_d[FLAG_TIMEOUT] = 1'b1;
                    state_d               = ST_HOLD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HOLD: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            add_a_q <= '0;
            add_b_q <= '0;
            res_q   <= '0;
            flags_q <= '0;
            cnt_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            add_a_q <= add_a_d;
            add_b_q <= add_b_d;
            res_q   <= res_d;
            flags_q <= flags_d;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
        end
    end

endmodule

// File: tb/tb_fp_op_dispatcher.sv
// Directed bench for fp_op_dispatcher: vector table plus hand-written sequences
// for stale done, timeout, back-pressure and mid-operation reset.
module tb_fp_op_dispatcher;
    localparam int MS    = 23;
    localparam int ES    = 8;
    localparam int N     = MS + ES;
    localparam int DEPTH = 4;
    localparam int TMO   = 32;
    localparam int NV    = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fp_op_dispatcher_if #(.N(N)) bus ();

    fp_op_dispatcher #(
        .Mantissa_Size (MS),
        .Exponent_Size (ES),
        .FIFO_DEPTH    (DEPTH),
        .TIMEOUT       (TMO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Adder model: one response record per add_load, updated 1 time unit after posedge.
    typedef struct {
        logic [N:0] res;
        logic [3:0] flg;   // {nan, overflow, underflow, zero}
        int         lat;
        int         stale;
        bit         never;
    } resp_t;

    resp_t      resp_q[$];
    logic [N:0] cap_a[$];
    logic [N:0] cap_b[$];
    int         n_loads   = 0;
    int         hold_errs = 0;

    task automatic push_resp(input logic [N:0] res, input logic [3:0] flg, input int lat,
                             input int stale, input bit never);
        resp_t r;
        r.res = res; r.flg = flg; r.lat = lat; r.stale = stale; r.never = never;
        resp_q.push_back(r);
    endtask

    initial begin
        resp_t      cur;
        logic [N:0] m_a, m_b;
        int         m_phase, m_stale, m_cnt, m_rd;
        bus.add_done = 1'b0; bus.add_result = '0;
        {bus.add_nan, bus.add_overflow, bus.add_underflow, bus.add_zero} = 4'b0000;
        m_phase = 0; m_stale = 0; m_cnt = 0; m_rd = 0; m_a = '0; m_b = '0;
        cur.res = '0; cur.flg = '0; cur.lat = 2; cur.stale = 0; cur.never = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                m_phase = 0;
                bus.add_done = 1'b0;
            end else if (bus.add_load) begin
                if (m_rd < resp_q.size()) begin
                    cur = resp_q[m_rd];
                    m_rd++;
                end else begin
                    cur.never = 1'b1;
                end
                m_a = bus.add_a; m_b = bus.add_b;
                cap_a.push_back(m_a); cap_b.push_back(m_b);
                n_loads++;
                m_stale = cur.stale; m_cnt = cur.lat;
                if (m_stale == 0) begin
                    bus.add_done = 1'b0;
                    m_phase = 2;
                end else begin
                    m_phase = 1;
                end
            end else begin
                if (m_phase != 0 && (bus.add_a !== m_a || bus.add_b !== m_b)) hold_errs++;
                if (m_phase == 1) begin
                    m_stale--;
                    if (m_stale == 0) begin
                        bus.add_done = 1'b0;
                        m_phase = 2;
                    end
                end else if (m_phase == 2 && !cur.never) begin
                    if (m_cnt > 0) m_cnt--;
                    if (m_cnt == 0) begin
                        bus.add_result = cur.res;
                        {bus.add_nan, bus.add_overflow, bus.add_underflow, bus.add_zero} = cur.flg;
                        bus.add_done = 1'b1;
                        m_phase = 0;
                    end
                end
            end
        end
    end

    // Called at a negedge; returns at a negedge with in_valid low.
    task automatic send(input logic [N:0] a, input logic [N:0] b, input logic op, output bit ok);
        int waited;
        waited = 0;
        bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b; bus.in_op = op;
        while (!bus.in_ready && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        ok = bus.in_ready;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic get_result(input logic [N:0] er, input logic [4:0] ef, input string nm,
                              output int waited);
        waited = 0;
        while (!bus.out_valid && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check({nm, " out_valid"}, bus.out_valid, 1'b1);
        check({nm, " out_result"}, bus.out_result, er);
        check({nm, " out_flags"}, bus.out_flags, ef);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({nm, " out_valid drop"}, bus.out_valid, 1'b0);
    endtask

    typedef struct {
        logic [N:0] a;
        logic [N:0] b;
        logic       op;
        int         lat;
        logic [N:0] res;
        logic [3:0] flg;
        logic [N:0] exp_b;
        logic [N:0] exp_res;
        logic [4:0] exp_flags;
    } vec_t;

    vec_t vec[NV];

    initial begin
        bit ok;
        int w, base, acc;
        logic [N:0] bp_res[5];
        logic [4:0] bp_flg[5];

        vec[0] = '{a:32'h40000000, b:32'h40000000, op:1'b0, lat:5, res:32'h40800000, flg:4'b0000,
                   exp_b:32'h40000000, exp_res:32'h40800000, exp_flags:5'b00000};
        vec[1] = '{a:32'h7F000007, b:32'h7F000007, op:1'b1, lat:3, res:32'h00000000, flg:4'b0001,
                   exp_b:32'hFF000007, exp_res:32'h00000000, exp_flags:5'b00001};
        vec[2] = '{a:32'h3F800000, b:32'hBF800000, op:1'b1, lat:2, res:32'h40000000, flg:4'b0000,
                   exp_b:32'h3F800000, exp_res:32'h40000000, exp_flags:5'b00000};
        vec[3] = '{a:32'h7F7FFFFF, b:32'h7F7FFFFF, op:1'b0, lat:4, res:32'h7F800000, flg:4'b0100,
                   exp_b:32'h7F7FFFFF, exp_res:32'h7F800000, exp_flags:5'b00100};
        vec[4] = '{a:32'h7FC00000, b:32'h3F800000, op:1'b0, lat:6, res:32'h7FC00000, flg:4'b1000,
                   exp_b:32'h3F800000, exp_res:32'h7FC00000, exp_flags:5'b01000};
        vec[5] = '{a:32'h00800000, b:32'h00800001, op:1'b1, lat:7, res:32'h80000001, flg:4'b0010,
                   exp_b:32'h80800001, exp_res:32'h80000001, exp_flags:5'b00010};

        bp_res[0] = 32'h41000000; bp_flg[0] = 5'b00000;
        bp_res[1] = 32'h41100000; bp_flg[1] = 5'b00001;
        bp_res[2] = 32'h41200000; bp_flg[2] = 5'b00010;
        bp_res[3] = 32'h41300000; bp_flg[3] = 5'b00100;
        bp_res[4] = 32'h41400000; bp_flg[4] = 5'b01000;

        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_op = 1'b0; bus.out_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst in_ready", bus.in_ready, 1'b0);
        check("rst add_enable", bus.add_enable, 1'b0);
        check("rst out_valid", bus.out_valid, 1'b0);
        check("rst add_load", bus.add_load, 1'b0);
        check("rst out_result", bus.out_result, 32'h0);
        check("rst out_flags", bus.out_flags, 5'h0);
        check("rst add_a", bus.add_a, 32'h0);
        check("rst add_b", bus.add_b, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post-rst out_valid", bus.out_valid, 1'b0);
        check("post-rst add_load", bus.add_load, 1'b0);
        check("post-rst in_ready", bus.in_ready, 1'b1);
        check("post-rst add_enable", bus.add_enable, 1'b1);

        // Vector table, one operation at a time
        for (int i = 0; i < NV; i++) begin
            int herr;
            push_resp(vec[i].res, vec[i].flg, vec[i].lat, 0, 1'b0);
            base = n_loads; herr = hold_errs;
            send(vec[i].a, vec[i].b, vec[i].op, ok);
            check($sformatf("vec%0d accept", i), ok, 1'b1);
            get_result(vec[i].exp_res, vec[i].exp_flags, $sformatf("vec%0d", i), w);
            check($sformatf("vec%0d latency", i), w + 1, vec[i].lat + 3);
            if (n_loads > base) begin
                check($sformatf("vec%0d add_a", i), cap_a[base], vec[i].a);
                check($sformatf("vec%0d add_b", i), cap_b[base], vec[i].exp_b);
            end else begin
                check($sformatf("vec%0d add_load seen", i), 1'b0, 1'b1);
            end
            check($sformatf("vec%0d operands held", i), hold_errs - herr, 0);
        end

        // Stale done: still high from the last vector, held 3 more cycles after the load
        push_resp(32'h11111111, 4'b0000, 3, 3, 1'b0);
        send(32'h3F800000, 32'h3F800000, 1'b0, ok);
        get_result(32'h11111111, 5'b00000, "stale done", w);
        check("stale done latency", w + 1, 3 + 3 + 3);

        // Timeout: adder never answers
        push_resp(32'hDEADBEEF, 4'b1111, 2, 0, 1'b1);
        send(32'h40400000, 32'h40400000, 1'b0, ok);
        w = 0;
        while (!bus.add_load && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("timeout add_load seen", bus.add_load, 1'b1);
        w = 0;
        while (!bus.out_valid && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("timeout cycles", w, TMO + 1);
        get_result(32'h0, 5'b10000, "timeout", w);

        // Back-pressure: 6 back-to-back requests with out_ready low
        for (int i = 0; i < 5; i++) push_resp(bp_res[i], bp_flg[i][3:0], 3, 0, 1'b0);
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            send(32'h3F800000 + i, 32'h40000000 + i, i[0], ok);
            if (ok) acc++;
        end
        check("bp accepted", acc, 5);
        check("bp in_ready", bus.in_ready, 1'b0);
        check("bp holding", bus.out_valid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            get_result(bp_res[i], bp_flg[i], $sformatf("bp%0d", i), w);
        end
        repeat (10) @(negedge clk);
        check("bp no extra result", bus.out_valid, 1'b0);

        // Reset mid-WAIT with two requests queued
        for (int i = 0; i < 3; i++) push_resp(32'hCAFE0000 + i, 4'b0000, 2, 0, 1'b1);
        base = n_loads;
        for (int i = 0; i < 3; i++) send(32'h40A00000, 32'h40A00000, 1'b0, ok);
        w = 0;
        while (n_loads == base && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("mid-rst engine started", n_loads, base + 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid-rst in_ready", bus.in_ready, 1'b0);
        check("mid-rst add_enable", bus.add_enable, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mid-rst out_valid", bus.out_valid, 1'b0);
        check("mid-rst add_load", bus.add_load, 1'b0);
        check("mid-rst add_a", bus.add_a, 32'h0);
        check("mid-rst add_b", bus.add_b, 32'h0);
        check("mid-rst out_flags", bus.out_flags, 5'h0);
        base = n_loads;
        acc = 0;
        repeat (60) begin
            @(negedge clk);
            if (bus.out_valid) acc++;
        end
        check("mid-rst no output", acc, 0);
        check("mid-rst fifo empty", n_loads - base, 0);
        check("mid-rst in_ready after", bus.in_ready, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
